// File: rtl/uart_pkg.sv
// Shared UART constants and the receive FSM state encoding.
// The TX path reuses DATA_BITS and the oversampling constants.
package uart_pkg;

  localparam int OVS_RATE        = 16;  // oversample ticks per bit
  localparam int DATA_BITS       = 8;   // 8N1 payload width
  localparam int MID_SAMPLE      = 7;   // sample index taken as the bit mid-point
  localparam int OVS_DIV_DEFAULT = 78;  // 12 MHz / (9600 * 16)
  localparam int TICK_CNT_W      = 12;  // holds OVS_DIV up to 4095
  localparam int SAMPLE_W        = $clog2(OVS_RATE);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversample tick generator: one-cycle tick every OVS_DIV clocks.
// Held at zero while clear is high so the tick phase lines up with the
// start edge that releases it.
module uart_rx_tick_gen
  import uart_pkg::*;
#(
  parameter int OVS_DIV = OVS_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam logic [TICK_CNT_W-1:0] LAST = TICK_CNT_W'(OVS_DIV - 1);

  logic [TICK_CNT_W-1:0] cnt_q;
  logic [TICK_CNT_W-1:0] cnt_d;

  // Next count: cleared, wrapped at the terminal count, or incremented.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = !clear && (cnt_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. The line is oversampled 16x and each bit is taken at
// its mid-point. Handshake: rx_valid stays high with rx_data stable until a
// cycle where rx_ready is high (the transfer); rx_valid drops on the next
// clk unless a new byte completes in that same cycle.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVS_DIV = OVS_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  logic                 sync1_q;
  logic                 rx_s_q;
  rx_state_e            state_q;
  logic [SAMPLE_W-1:0]  sample_q;
  logic [2:0]           idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 frame_err_q;
  logic                 overrun_q;

  logic tick;
  logic tick_clear;
  logic mid_bit;
  logic accept;

  // Two-flop synchronizer for the asynchronous pin; resets to idle-high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= rx;
      rx_s_q  <= sync1_q;
    end
  end

  // Tick phase restarts from the start edge, so hold it cleared in IDLE.
  assign tick_clear = (state_q == ST_IDLE);

  uart_rx_tick_gen #(
    .OVS_DIV (OVS_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (tick_clear),
    .tick  (tick)
  );

  assign mid_bit = tick && (sample_q == SAMPLE_W'(MID_SAMPLE));
  assign accept  = rx_valid_q && rx_ready;

  // Sample counter: counts ticks within a bit, wraps every OVS_RATE ticks.
  always_ff @(posedge clk) begin
    if (rst || (state_q == ST_IDLE)) begin
      sample_q <= '0;
    end else if (tick) begin
      sample_q <= sample_q + 1'b1;
    end
  end

  // Receive FSM with registered data, valid, frame-error and overrun outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      if (accept) begin
        rx_valid_q <= 1'b0;
      end
      case (state_q)
        ST_IDLE: begin
          if (!rx_s_q) begin
            idx_q   <= '0;
            state_q <= ST_START;
          end
        end
        ST_START: begin
          // A line that is high again at mid-start was a glitch.
          if (mid_bit) begin
            state_q <= rx_s_q ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (mid_bit) begin
            shift_q[idx_q] <= rx_s_q;
            idx_q          <= idx_q + 3'd1;
            if (idx_q == 3'(DATA_BITS - 1)) begin
              state_q <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (mid_bit) begin
            if (rx_s_q) begin
              // Old byte still pending and not taken this cycle: drop new one.
              if (rx_valid_q && !rx_ready) begin
                overrun_q <= 1'b1;
              end else begin
                rx_data_q  <= shift_q;
                rx_valid_q <= 1'b1;
              end
              state_q <= ST_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          // Ride out a long low line so it yields a single frame error.
          if (rx_s_q) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized bench for uart_rx at OVS_DIV=4 (64 clocks/bit).
module tb_uart_rx;

  localparam int OVS_DIV  = 4;
  localparam int BIT_CLKS = 16 * OVS_DIV;
  localparam int LAT_NOM  = 2 + OVS_DIV * (16 * 9 + 8);

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx #(.OVS_DIV(OVS_DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_mem [0:255];
  int         got_n = 0;
  int         rd_idx = 0;
  int         fe_cnt = 0;
  int         vrise_cnt = 0;
  logic       prev_valid = 1'b0;

  // Observe the handshake half a cycle after the drivers settle.
  always @(negedge clk) begin
    #1;
    if (frame_err) fe_cnt++;
    if (rx_valid && !prev_valid) vrise_cnt++;
    if (rx_valid && rx_ready && !rst) begin
      got_mem[got_n % 256] = rx_data;
      got_n++;
    end
    prev_valid = rx_valid;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- check / driver tasks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic drive_bit(input logic v, input int n);
    @(negedge clk);
    rx = v;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input int bclk, input logic stop_val);
    drive_bit(1'b0, bclk);
    for (int i = 0; i < 8; i++) drive_bit(b[i], bclk);
    drive_bit(stop_val, bclk);
  endtask

  task automatic idle(input int n);
    drive_bit(1'b1, n);
  endtask

  // Drain the expected queue against the bytes actually transferred.
  task automatic check_rx(input string tag);
    logic [7:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd_idx < got_n) chk(tag, {24'd0, got_mem[rd_idx % 256]}, {24'd0, e});
      else                chk({tag, "_missing"}, 32'hDEAD, {24'd0, e});
      rd_idx++;
    end
    chk({tag, "_count"}, got_n, rd_idx);
  endtask

  // ---------------- stimulus ----------------
  int         lat;
  int         fe0;
  int         vr0;
  int         bclk;
  int         n_good;
  int         n_bad;
  logic [7:0] b;
  logic [7:0] b5[3];

  initial begin
    b5[0] = 8'h00; b5[1] = 8'hFF; b5[2] = 8'h80;

    // Reset
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_rx_data", {24'd0, rx_data}, 32'd0);
    chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
    chk("reset_overrun", {31'd0, overrun}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);

    // 1. single byte, latency from falling edge
    fe0 = fe_cnt; vr0 = vrise_cnt; lat = -1;
    fork
      send_frame(8'hA5, BIT_CLKS, 1'b1);
      begin
        wait (rx === 1'b0);
        for (int c = 1; c <= 700; c++) begin
          @(negedge clk);
          #1;
          if (rx_valid) begin
            lat = c - 1;
            break;
          end
        end
      end
    join
    n_checks++;
    assert (lat >= LAT_NOM - 1 && lat <= LAT_NOM + 1) n_pass++;
    else $error("FAIL s1_latency: observed %0d expected %0d +/-1", lat, LAT_NOM);
    idle(40);
    exp_q.push_back(8'hA5);
    check_rx("s1_byte");
    chk("s1_valid_pulses", vrise_cnt - vr0, 1);
    chk("s1_frame_err", fe_cnt - fe0, 0);
    chk("s1_overrun", {31'd0, overrun}, 32'd0);

    // 2. short low glitch is ignored
    fe0 = fe_cnt; vr0 = vrise_cnt;
    drive_bit(1'b0, 20);
    idle(60);
    #1;
    chk("s2_glitch_idle", {31'd0, busy}, 32'd0);
    chk("s2_glitch_no_valid", vrise_cnt - vr0, 0);
    send_frame(8'h3C, BIT_CLKS, 1'b1);
    idle(40);
    exp_q.push_back(8'h3C);
    check_rx("s2_byte");
    chk("s2_frame_err", fe_cnt - fe0, 0);

    // 3. framing error followed by a long break
    fe0 = fe_cnt; vr0 = vrise_cnt;
    send_frame(8'h55, BIT_CLKS, 1'b0);
    drive_bit(1'b0, 500);
    #1;
    chk("s3_busy_in_break", {31'd0, busy}, 32'd1);
    chk("s3_one_frame_err", fe_cnt - fe0, 1);
    chk("s3_no_valid", vrise_cnt - vr0, 0);
    idle(20);
    #1;
    chk("s3_idle_after_break", {31'd0, busy}, 32'd0);
    send_frame(8'h01, BIT_CLKS, 1'b1);
    idle(40);
    exp_q.push_back(8'h01);
    check_rx("s3_byte");
    chk("s3_frame_err_total", fe_cnt - fe0, 1);

    // 4. overrun while consumer stalls
    vr0 = vrise_cnt;
    @(negedge clk);
    rx_ready = 1'b0;
    send_frame(8'h11, BIT_CLKS, 1'b1);
    send_frame(8'h22, BIT_CLKS, 1'b1);
    idle(20);
    #1;
    chk("s4_valid_held", {31'd0, rx_valid}, 32'd1);
    chk("s4_data_kept", {24'd0, rx_data}, 32'h11);
    chk("s4_overrun_set", {31'd0, overrun}, 32'd1);
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("s4_valid_cleared", {31'd0, rx_valid}, 32'd0);
    chk("s4_overrun_sticky", {31'd0, overrun}, 32'd1);
    exp_q.push_back(8'h11);
    check_rx("s4_byte");
    chk("s4_valid_pulses", vrise_cnt - vr0, 1);

    // 6. reset in the middle of data bit 4
    b = 8'h96;
    drive_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) drive_bit(b[i], BIT_CLKS);
    drive_bit(b[4], BIT_CLKS / 2);
    #1;
    chk("s6_busy_mid_frame", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("s6_rx_data", {24'd0, rx_data}, 32'd0);
    chk("s6_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("s6_frame_err", {31'd0, frame_err}, 32'd0);
    chk("s6_overrun", {31'd0, overrun}, 32'd0);
    chk("s6_busy", {31'd0, busy}, 32'd0);
    rd_idx = got_n;
    idle(20);
    send_frame(8'h69, BIT_CLKS, 1'b1);
    idle(40);
    exp_q.push_back(8'h69);
    check_rx("s6_byte");

    // 5. back-to-back frames at +2% and -2% bit period
    fe0 = fe_cnt; vr0 = vrise_cnt;
    for (int i = 0; i < 3; i++) begin
      send_frame(b5[i], BIT_CLKS + 1, 1'b1);
      exp_q.push_back(b5[i]);
    end
    for (int i = 0; i < 3; i++) begin
      send_frame(b5[i], BIT_CLKS - 1, 1'b1);
      exp_q.push_back(b5[i]);
    end
    idle(40);
    check_rx("s5_byte");
    chk("s5_valid_pulses", vrise_cnt - vr0, 6);
    chk("s5_frame_err", fe_cnt - fe0, 0);
    chk("s5_overrun", {31'd0, overrun}, 32'd0);

    // 7. random bytes, rates, gaps and occasional bad stop bits
    fe0 = fe_cnt; vr0 = vrise_cnt; n_good = 0; n_bad = 0;
    for (int i = 0; i < 12; i++) begin
      b    = 8'($urandom_range(0, 255));
      bclk = $urandom_range(BIT_CLKS - 2, BIT_CLKS + 2);
      if ($urandom_range(0, 3) == 0) begin
        send_frame(b, bclk, 1'b0);
        idle(80);
        n_bad++;
      end else begin
        send_frame(b, bclk, 1'b1);
        exp_q.push_back(b);
        n_good++;
        idle($urandom_range(1, 40));
      end
    end
    idle(40);
    check_rx("rnd_byte");
    chk("rnd_frame_errs", fe_cnt - fe0, n_bad);
    chk("rnd_valid_pulses", vrise_cnt - vr0, n_good);
    chk("rnd_overrun", {31'd0, overrun}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
